fir_3rd_order: RTL and testbench

FIR_3RD_ORDER -- requirements
Module: fir_3rd_order

---
 rtl/fir_3rd_order_pkg.sv | 38 +++
 rtl/fir_delay_stage.sv | 23 ++
 rtl/fir_3rd_order.sv | 50 +++++
 tb/tb_fir_3rd_order.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fir_3rd_order_pkg.sv
// Shared widths and default coefficients for the 4-tap direct-form FIR.
// Also holds the multiply-accumulate helper used by the top level.
//   SAMPLE_W : sample width (unsigned)
//   COEF_W   : coefficient width (unsigned)
//   PROD_W   : width of one coefficient*sample product
//   OUT_W    : width of the full-precision sum
//   TAPS     : number of taps (x[n] .. x[n-3])
package fir_3rd_order_pkg;

  localparam int SAMPLE_W = 4;
  localparam int COEF_W   = 4;
  localparam int PROD_W   = SAMPLE_W + COEF_W;
  localparam int OUT_W    = 10;
  localparam int TAPS     = 4;

  localparam logic [COEF_W-1:0] DEF_H0 = 4'd1;
  localparam logic [COEF_W-1:0] DEF_H1 = 4'd2;
  localparam logic [COEF_W-1:0] DEF_H2 = 4'd3;
  localparam logic [COEF_W-1:0] DEF_H3 = 4'd4;

  typedef logic [TAPS-1:0][SAMPLE_W-1:0] tap_vec_t;
  typedef logic [TAPS-1:0][COEF_W-1:0]   coef_vec_t;

  // Sum of c[k]*s[k]. Each 8-bit product is zero-extended to OUT_W before
  // accumulation, so 4*15*15 = 900 is reached without wrap.
  function automatic logic [OUT_W-1:0] fir_mac(input tap_vec_t s,
                                               input coef_vec_t c);
    logic [OUT_W-1:0]  acc;
    logic [PROD_W-1:0] prod;
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod = PROD_W'(c[k]) * PROD_W'(s[k]);
      acc  = acc + OUT_W'(prod);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fir_delay_stage.sv
// One stage of the FIR delay line: a W-bit register with synchronous,
// active-high reset.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears q
//   d   : next sample
//   q   : sample delayed by one clock
module fir_delay_stage
  import fir_3rd_order_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/fir_3rd_order.sv
// 4-tap (3rd-order) direct-form FIR with registered output.
//   Y <= H0*X + H1*D1 + H2*D2 + H3*D3, one cycle latency, one sample/cycle.
// Ports:
//   X   : unsigned input sample, taken every rising Clk edge
//   Rst : synchronous active-high reset, clears delay line and Y
//   Clk : rising-edge clock
//   Y   : unsigned full-precision registered output
module fir_3rd_order
  import fir_3rd_order_pkg::*;
#(
  parameter logic [COEF_W-1:0] H0 = DEF_H0,
  parameter logic [COEF_W-1:0] H1 = DEF_H1,
  parameter logic [COEF_W-1:0] H2 = DEF_H2,
  parameter logic [COEF_W-1:0] H3 = DEF_H3
) (
  input  logic [SAMPLE_W-1:0] X,
  input  logic                Rst,
  input  logic                Clk,
  output logic [OUT_W-1:0]    Y
);

  // coef[k] multiplies tap[k]; tap[0] is the live input, tap[k] is x[n-k].
  localparam coef_vec_t COEFS = {H3, H2, H1, H0};

  tap_vec_t         tap;
  logic [OUT_W-1:0] sum;

  assign tap[0] = X;

  // D1..D3: each stage feeds the next, all updating on the same edge so
  // the MAC below sees pre-edge values.
  for (genvar k = 1; k < TAPS; k++) begin : g_dly
    fir_delay_stage #(.W(SAMPLE_W)) u_dly (
      .clk (Clk),
      .rst (Rst),
      .d   (tap[k-1]),
      .q   (tap[k])
    );
  end

  always_comb begin
    sum = fir_mac(tap, COEFS);
  end

  always_ff @(posedge Clk) begin
    if (Rst) Y <= '0;
    else     Y <= sum;
  end

endmodule

// File: tb/tb_fir_3rd_order.sv
// Scoreboard bench for fir_3rd_order: default-coefficient DUT plus an
// all-15 coefficient DUT sharing the same stimulus.
module tb_fir_3rd_order;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] X   = 4'd0;
  logic [9:0] Y, Y_fs;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [9:0] y;
    logic       chk_fs;
    logic [9:0] y_fs;
    string      name;
  } sb_t;

  sb_t sb_q[$];
  sb_t cur;

  always #5 Clk = ~Clk;

  fir_3rd_order dut (
    .X   (X),
    .Rst (Rst),
    .Clk (Clk),
    .Y   (Y)
  );

  fir_3rd_order #(.H0(4'd15), .H1(4'd15), .H2(4'd15), .H3(4'd15)) dut_fs (
    .X   (X),
    .Rst (Rst),
    .Clk (Clk),
    .Y   (Y_fs)
  );

  // Inputs change on the falling edge; expectation is queued right after the
  // rising edge that consumes them, and the monitor pops on the next falling
  // edge, so pushes and pops never share a timestep.
  task automatic drive(input logic [3:0] x, input logic r, input logic [9:0] e,
                       input logic cf, input logic [9:0] ef, input string nm);
    sb_t s;
    @(negedge Clk);
    X   = x;
    Rst = r;
    @(posedge Clk);
    s.y = e; s.chk_fs = cf; s.y_fs = ef; s.name = nm;
    sb_q.push_back(s);
  endtask

  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      n_checks++;
      if (Y !== cur.y) begin
        n_errors++;
        $display("FAIL %s: Y=%0d expected %0d", cur.name, Y, cur.y);
      end
      if (cur.chk_fs) begin
        n_checks++;
        if (Y_fs !== cur.y_fs) begin
          n_errors++;
          $display("FAIL %s_fs: Y=%0d expected %0d", cur.name, Y_fs, cur.y_fs);
        end
      end
    end
  end

  initial begin
    // reset held two edges with X=7
    drive(4'd7, 1'b1, 10'd0, 1'b1, 10'd0, "rst0");
    drive(4'd7, 1'b1, 10'd0, 1'b1, 10'd0, "rst1");

    // impulse response
    drive(4'd1, 1'b0, 10'd1, 1'b0, 10'd0, "imp0");
    drive(4'd0, 1'b0, 10'd2, 1'b0, 10'd0, "imp1");
    drive(4'd0, 1'b0, 10'd3, 1'b0, 10'd0, "imp2");
    drive(4'd0, 1'b0, 10'd4, 1'b0, 10'd0, "imp3");
    drive(4'd0, 1'b0, 10'd0, 1'b0, 10'd0, "imp4");

    // ramp
    drive(4'd7, 1'b1, 10'd0, 1'b0, 10'd0, "rst_ramp");
    drive(4'd1, 1'b0, 10'd1,  1'b0, 10'd0, "ramp0");
    drive(4'd2, 1'b0, 10'd4,  1'b0, 10'd0, "ramp1");
    drive(4'd3, 1'b0, 10'd10, 1'b0, 10'd0, "ramp2");
    drive(4'd4, 1'b0, 10'd20, 1'b0, 10'd0, "ramp3");
    drive(4'd0, 1'b0, 10'd25, 1'b0, 10'd0, "ramp4");
    drive(4'd0, 1'b0, 10'd24, 1'b0, 10'd0, "ramp5");
    drive(4'd0, 1'b0, 10'd16, 1'b0, 10'd0, "ramp6");
    drive(4'd0, 1'b0, 10'd0,  1'b0, 10'd0, "ramp7");

    // full scale input, both coefficient sets
    drive(4'd7,  1'b1, 10'd0,   1'b1, 10'd0,   "rst_fs");
    drive(4'd15, 1'b0, 10'd15,  1'b1, 10'd225, "fs0");
    drive(4'd15, 1'b0, 10'd45,  1'b1, 10'd450, "fs1");
    drive(4'd15, 1'b0, 10'd90,  1'b1, 10'd675, "fs2");
    drive(4'd15, 1'b0, 10'd150, 1'b1, 10'd900, "fs3");
    drive(4'd15, 1'b0, 10'd150, 1'b1, 10'd900, "fs4");
    drive(4'd15, 1'b0, 10'd150, 1'b1, 10'd900, "fs5");

    // reset from full history, X still 15: output must clear
    drive(4'd15, 1'b1, 10'd0, 1'b1, 10'd0, "rst_hist");

    // mid-stream reset during a ramp, then history must be gone
    drive(4'd1, 1'b0, 10'd1,  1'b0, 10'd0, "mid0");
    drive(4'd2, 1'b0, 10'd4,  1'b0, 10'd0, "mid1");
    drive(4'd3, 1'b0, 10'd10, 1'b0, 10'd0, "mid2");
    drive(4'd9, 1'b1, 10'd0,  1'b1, 10'd0, "mid_rst");
    drive(4'd2, 1'b0, 10'd2,  1'b1, 10'd30, "mid3");
    drive(4'd0, 1'b0, 10'd4,  1'b1, 10'd30, "mid4");
    drive(4'd0, 1'b0, 10'd6,  1'b1, 10'd30, "mid5");
    drive(4'd0, 1'b0, 10'd8,  1'b1, 10'd30, "mid6");
    drive(4'd0, 1'b0, 10'd0,  1'b1, 10'd0,  "mid7");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge Clk);
    #1;
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
